// File: rtl/wb_ddr2_port_arb.sv
// Two-master Wishbone arbiter in front of a single DDR2 controller slave port.
// Round-robin on ties, grant held for the whole cyc, forced error after TIMEOUT wait cycles.
module wb_ddr2_port_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [2:0]  m0_cti_i,
    input  logic [1:0]  m0_bte_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [2:0]  m1_cti_i,
    input  logic [1:0]  m1_bte_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic [2:0]  s_cti_o,
    output logic [1:0]  s_bte_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] wait_q, wait_d;
    logic        sel0, sel1, m_stb, term, timeout_hit;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wait_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs are gated with wb_rst so an asserted reset silences both sides immediately.
    always_comb begin
        sel0    = (state_q == GNT0) && !wb_rst;
        sel1    = (state_q == GNT1) && !wb_rst;
        s_adr_o = 32'd0;
        s_dat_o = 32'd0;
        s_sel_o = 4'd0;
        s_cti_o = 3'd0;
        s_bte_o = 2'd0;
        s_cyc_o = 1'b0;
        s_we_o  = 1'b0;
        m_stb   = 1'b0;
        if (sel0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_cti_o = m0_cti_i;
            s_bte_o = m0_bte_i;
            s_cyc_o = m0_cyc_i;
            s_we_o  = m0_we_i;
            m_stb   = m0_stb_i;
        end else if (sel1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_cti_o = m1_cti_i;
            s_bte_o = m1_bte_i;
            s_cyc_o = m1_cyc_i;
            s_we_o  = m1_we_i;
            m_stb   = m1_stb_i;
        end
        term        = s_ack_i || s_err_i || s_rty_i;
        // A real slave termination in the last wait cycle wins over the forced error.
        timeout_hit = s_cyc_o && m_stb && !term && (wait_q == WAIT_LAST);
        s_stb_o     = m_stb && !timeout_hit;

        m0_dat_o = 32'd0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        if (sel0) begin
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i || timeout_hit;
            m0_rty_o = s_rty_i;
        end else if (sel1) begin
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i || timeout_hit;
            m1_rty_o = s_rty_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && !m1_cyc_i)      state_d = GNT0;
                else if (m1_cyc_i && !m0_cyc_i) state_d = GNT1;
                else if (m0_cyc_i && m1_cyc_i)  state_d = last_q ? GNT0 : GNT1;
            end
            GNT0: if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
            GNT1: if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
            default: state_d = IDLE;
        endcase

        last_d = last_q;
        if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;
        if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;

        // The forced-error cycle drops s_stb_o, so it also clears the counter here.
        wait_d = 16'd0;
        if (state_d == state_q && s_cyc_o && s_stb_o && !term) wait_d = wait_q + 16'd1;

        dbg_state_o = state_q;
    end

endmodule
